// File: rtl/vc_fifo_flow.sv
// Per-VC FIFO (depth 2**ADDR_WIDTH, 1-cycle registered pop) with threshold pause/continue pulses.
// A full FIFO still accepts a write when a pop happens that cycle; otherwise the word is dropped and error_full latches.
module vc_fifo_flow #(
   parameter int DATA_WIDTH   = 6,
   parameter int ADDR_WIDTH   = 4,
   parameter int THR_HIGH_RST = 12,
   parameter int THR_LOW_RST  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  init,
   input  logic [ADDR_WIDTH:0]   thr_high_in,
   input  logic [ADDR_WIDTH:0]   thr_low_in,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  pause,
   output logic                  continue_flow,
   output logic                  error_full
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_V = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] THR_H0  = THR_HIGH_RST[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] THR_L0  = THR_LOW_RST[ADDR_WIDTH:0];

   typedef enum logic {FLOWING, PAUSED} flow_t;

   flow_t                 state, state_nxt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [ADDR_WIDTH:0]   thr_high, thr_low;
   logic                  rd_acc, wr_acc, overflow, thr_ok;

   assign empty    = (count == '0);
   assign full     = (count == DEPTH_V);
   // A full FIFO is never empty, so rd_en on full always frees a slot this cycle.
   assign rd_acc   = rd_en && !empty;
   assign wr_acc   = wr_en && (!full || rd_en);
   assign overflow = wr_en && full && !rd_en;
   assign thr_ok   = (thr_low_in < thr_high_in) && (thr_high_in <= DEPTH_V);

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         error_full <= 1'b0;
         thr_high   <= THR_H0;
         thr_low    <= THR_L0;
         state      <= FLOWING;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) begin
            rd_ptr   <= rd_ptr + 1'b1;
            data_out <= mem[rd_ptr];
         end
         data_valid <= rd_acc;
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (overflow) error_full <= 1'b1;
         if (init && thr_ok) begin
            thr_high <= thr_high_in;
            thr_low  <= thr_low_in;
         end
         state <= state_nxt;
      end
   end

   // Pulses are suppressed during init; releasing init re-evaluates the same cycle.
   always_comb begin
      pause         = 1'b0;
      continue_flow = 1'b0;
      state_nxt     = state;
      if (init) begin
         state_nxt = FLOWING;
      end else begin
         case (state)
            FLOWING: if (count >= thr_high) begin
               pause     = 1'b1;
               state_nxt = PAUSED;
            end
            PAUSED: if (count <= thr_low) begin
               continue_flow = 1'b1;
               state_nxt     = FLOWING;
            end
            default: state_nxt = FLOWING;
         endcase
      end
   end

endmodule

// File: doc/vc_fifo_flow.md
Name: vc_fifo_flow

Overview:
- One virtual-channel FIFO with threshold-based flow control. Four instances sit directly upstream of the control FSM, one per virtual channel (VC0..VC3).
- Buffers channel data and reports status to the FSM on a per-channel basis:
  - empty
  - pause pulse when the high threshold is reached
  - continue pulse when occupancy drains to the low threshold
  - sticky full-overflow error
- High/low thresholds are programmable only while the FSM holds init high.

Parameters:
- DATA_WIDTH, 6, width of one FIFO word
- ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH = 16
- THR_HIGH_RST, 12, reset value of the high (pause) threshold
- THR_LOW_RST, 4, reset value of the low (continue) threshold

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- init  in  1  threshold-programming window, driven by the control FSM
- thr_high_in  in  ADDR_WIDTH+1  high threshold value, sampled while init=1
- thr_low_in  in  ADDR_WIDTH+1  low threshold value, sampled while init=1
- wr_en  in  1  push request
- data_in  in  DATA_WIDTH  push data
- rd_en  in  1  pop request
- data_out  out  DATA_WIDTH  registered pop data
- data_valid  out  1  data_out holds a word popped the previous cycle
- count  out  ADDR_WIDTH+1  current occupancy, 0..16
- empty  out  1  count==0
- full  out  1  count==16
- pause  out  1  one-cycle pause pulse
- continue  out  1  one-cycle continue pulse
- error_full  out  1  sticky overflow error

Behaviour:
- Reset (rst=0, async):
  - pointers=0, count=0, empty=1, full=0
  - data_out=0, data_valid=0, pause=0, continue=0, error_full=0
  - thr_high=THR_HIGH_RST, thr_low=THR_LOW_RST, flow state=FLOWING
- Reset mid-operation clears all contents immediately. Stored data is lost.
- Read:
  - Accepted when rd_en && !empty.
  - data_out <= mem[rd_ptr], data_valid=1 on the following cycle, rd_ptr+1.
  - Latency 1. data_valid=0 on any cycle after a non-accepted read; data_out holds its last value.
- Write:
  - Accepted when wr_en && (!full || rd_en). mem[wr_ptr] <= data_in, wr_ptr+1.
- Pointers wrap modulo 16 naturally.
- count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous wr_en/rd_en:
  - when full: both accepted, count stays 16, no error.
  - when empty: write accepted, read ignored (no bypass), data_valid=0 next cycle.
- Overflow:
  - wr_en && full && !rd_en: word dropped, pointers unchanged, error_full <= 1.
  - error_full holds until reset. All other FIFO operations continue normally.
- Pop on empty: ignored, no error.
- Threshold load (init=1):
  - Each cycle thr_high/thr_low <= inputs only if thr_low_in < thr_high_in and thr_high_in <= 16. Otherwise the previous values are kept.
  - Loading does not touch FIFO contents.
- Flow FSM, 2 states, evaluated on registered count:
  - FLOWING: pause = (count >= thr_high) && !init. If pause=1, next state PAUSED.
  - PAUSED: continue = (count <= thr_low) && !init. If continue=1, next state FLOWING.
  - pause and continue are combinational from registers. Each is high exactly one cycle per transition and never both in the same cycle.
  - While init=1: state forced to FLOWING at next edge, pulses held at 0.
  - On init deassertion, thresholds are re-evaluated against the current count the same cycle.
- Hysteresis: occupancy oscillating strictly between thr_low and thr_high produces no further pulses.

Test Plan:
- Reset then 3 writes (0x01,0x02,0x03), 3 reads -> data_out 0x01,0x02,0x03 each one cycle after its rd_en with data_valid=1; count 3->0; empty=1 at end.
- Defaults, write 12 words with no reads -> pause=1 for exactly the cycle count==12, state PAUSED. Read down to count 4 -> continue=1 one cycle at count==4; no pulses at counts 5..11.
- Fill to 16, then wr_en=1/rd_en=0 -> error_full=1 next cycle, count stays 16, dropped word never appears. Then wr_en=rd_en=1 -> count 16, no change to error state. error_full clears only on rst=0.
- init=1 with thr_high_in=8, thr_low_in=2 -> pause at count 8, continue at 2. init=1 with thr_high_in=3, thr_low_in=5 -> rejected, thresholds stay 8/2.
- Empty FIFO, wr_en=rd_en=1 same cycle -> count 1, data_valid=0 next cycle. Write 20 words/read 20 words interleaved -> pointer wrap, data order preserved.
- Assert rst=0 asynchronously mid-burst at count 10 with state PAUSED -> all outputs at reset values before the next clk edge; state FLOWING.
